udp_rx_kernel_packer: RTL and testbench
=======================================

Name: udp_rx_kernel_packer

Overview:
- Kernel-clock stage directly downstream of the UDP offload RX payload FIFO.
- Consumes the 64-bit show-ahead payload stream and packs OUT_WORDS consecutive words into one wide kernel-side word.
- Flushes a partially filled word after an idle timeout, so short UDP payloads reach the kernel.
- Exposes word and flush counters for the UDP OE status path.

Parameters:
OUT_WORDS, 2, number of 64-bit lanes per output word (legal values 2..8)
FLUSH_TIMEOUT, 256, idle kernel_clk cycles before a partial word is flushed (legal values 1..65535)
CNT_W, 32, width of word_count

Ports:
kernel_clk  in  1  clock; all logic in this domain
kernel_resetn  in  1  reset, asynchronous, active-low
in_valid  in  1  payload word available (FIFO non-empty)
in_data  in  64  payload word (show-ahead)
in_ready  out  1  word consumed this cycle (FIFO rd_ack)
out_valid  out  1  packed word valid
out_data  out  64*OUT_WORDS  packed word; lane 0 = [63:0] = oldest input word
out_keep  out  OUT_WORDS  per-lane valid mask
out_ready  in  1  kernel accepts packed word
flush_en  in  1  enables timeout flush (quasi-static)
word_count  out  CNT_W  accepted input words, wraps
flush_count  out  16  timeout flushes issued, saturates at 0xFFFF

Behaviour:
- Input accept: accept = in_valid & in_ready. Output accept: oacc = out_valid & out_ready.
- Structure: accumulator (OUT_WORDS lanes, fill index fill_idx, 0..OUT_WORDS-1) plus output register.
- in_ready = ~out_valid | out_ready | (fill_idx != OUT_WORDS-1). Combinational; depends only on registered state and out_ready.
- Lane fill:
  - An accepted word writes lane fill_idx; fill_idx increments.
  - When the word fills the last lane, the full accumulator moves to the output register on the same edge, with out_keep = all ones, and fill_idx returns to 0.
  - Latency from accepting the last-lane word to out_valid is 1 cycle.
- Output register:
  - out_valid, out_data and out_keep hold stable while out_valid & ~out_ready.
  - On oacc with no new load, out_valid clears next cycle.
  - Back-to-back: a load in the same cycle as oacc keeps out_valid high with the new data.
- Idle timer:
  - 16-bit counter, cleared on any accept and whenever fill_idx == 0; otherwise increments each cycle, saturating.
- Flush:
  - Fires when flush_en & fill_idx != 0 & timer == FLUSH_TIMEOUT-1 & ~in_valid & (~out_valid | out_ready).
  - Moves the partial accumulator to the output register. out_keep has ones in lanes 0..fill_idx-1; unfilled lanes of out_data are 0.
  - fill_idx returns to 0 and flush_count increments.
- Simultaneous events:
  - in_valid on the expiry cycle: accept wins, no flush, timer clears.
  - Expiry while the output register is stalled: flush waits until the output register is free; the timer holds at saturation.
- flush_en low: partial words wait indefinitely for more input.
- FSM, state encoded as fill_idx plus out_valid:
  - EMPTY: fill_idx 0, ~out_valid.
  - FILLING: fill_idx > 0.
  - HOLD: out_valid.
  - FILLING and HOLD may coexist.
- Reset, asynchronous and valid at any point including mid-packet:
  - out_valid 0, out_data 0, out_keep 0, fill_idx 0, timer 0, word_count 0, flush_count 0.
  - Partial data is discarded.
  - in_ready evaluates to 1 during and after reset.
- word_count: +1 per accept, wraps modulo 2^CNT_W. flush_count saturates at 0xFFFF.

Optional Feature:
- UDP_RX_BYTESWAP_EN defined: each 64-bit lane is byte-reversed on capture (in_data[7:0] lands in lane[63:56]), converting network to host byte order. No latency change.
- Not defined: lanes are stored unmodified.

Test Plan:
- OUT_WORDS=2, out_ready=1; input words 0x1111, 0x2222 on consecutive cycles -> one cycle later out_valid=1, out_data={0x2222,0x1111}, out_keep=2'b11; word_count=2.
- OUT_WORDS=2, FLUSH_TIMEOUT=8, flush_en=1; single word 0xAAAA then idle -> exactly 8 cycles after the accept, the next edge gives out_valid=1, out_data[63:0]=0xAAAA, upper lane 0, out_keep=2'b01; flush_count=1.
- Same config with flush_en=0; single word, idle 1000 cycles -> no out_valid. Second word 0xBBBB -> out_data={0xBBBB,0xAAAA}, keep=2'b11.
- out_ready=0, continuous in_valid, OUT_WORDS=2 -> two words packed into HOLD, third word accepted into lane 0, then in_ready=0. Raising out_ready drains {w1,w0}, then {w3,w2}, with no loss or duplication.
- Reset asserted after one of two lanes filled -> out_valid=0, counters 0. Next two words produce a packet containing only the post-reset words.
- UDP_RX_BYTESWAP_EN defined; input 0x0102030405060708 twice -> each lane of out_data = 0x0807060504030201.

Source files
------------

// File: rtl/udp_rx_kernel_packer.sv
// Packs OUT_WORDS consecutive 64-bit RX payload words into one wide kernel word, with idle flush.
// Define UDP_RX_BYTESWAP_EN to byte-reverse each lane on capture (network to host order).
module udp_rx_kernel_packer #(
    parameter int unsigned OUT_WORDS     = 2,
    parameter int unsigned FLUSH_TIMEOUT = 256,
    parameter int unsigned CNT_W         = 32
) (
    input  logic                      kernel_clk,
    input  logic                      kernel_resetn,
    input  logic                      in_valid,
    input  logic [63:0]               in_data,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [64*OUT_WORDS-1:0]   out_data,
    output logic [OUT_WORDS-1:0]      out_keep,
    input  logic                      out_ready,
    input  logic                      flush_en,
    output logic [CNT_W-1:0]          word_count,
    output logic [15:0]               flush_count
);

    localparam int unsigned      IDX_W    = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_WORDS - 1);
    localparam logic [15:0]      TMO_MAX  = 16'(FLUSH_TIMEOUT - 1);

    logic [OUT_WORDS-1:0][63:0] r_acc;
    logic [OUT_WORDS-1:0][63:0] w_acc_nxt;
    logic [OUT_WORDS-1:0][63:0] r_out_data;
    logic [OUT_WORDS-1:0]       r_out_keep;
    logic [OUT_WORDS-1:0]       w_flush_keep;
    logic [IDX_W-1:0]           r_fill_idx;
    logic [15:0]                r_timer;
    logic                       r_out_valid;
    logic [CNT_W-1:0]           r_word_count;
    logic [15:0]                r_flush_count;
    logic [63:0]                w_lane;
    logic                       w_accept;
    logic                       w_load;
    logic                       w_flush;
    logic                       w_oacc;
    logic                       w_out_free;

`ifdef UDP_RX_BYTESWAP_EN
    always_comb begin
        w_lane = '0;
        for (int b = 0; b < 8; b++) begin
            w_lane[8*b +: 8] = in_data[8*(7-b) +: 8];
        end
    end
`else
    assign w_lane = in_data;
`endif

    assign w_out_free = ~r_out_valid | out_ready;
    assign in_ready   = w_out_free | (r_fill_idx != LAST_IDX);
    assign w_accept   = in_valid & in_ready;
    assign w_oacc     = r_out_valid & out_ready;
    assign w_load     = w_accept & (r_fill_idx == LAST_IDX);
    // Input has priority over the timeout, so a flush never races an arriving word.
    assign w_flush    = flush_en & (r_fill_idx != '0) & (r_timer == TMO_MAX) & ~in_valid &
                        w_out_free;

    always_comb begin
        w_acc_nxt = r_acc;
        if (w_accept) begin
            w_acc_nxt[r_fill_idx] = w_lane;
        end
    end

    always_comb begin
        w_flush_keep = '0;
        for (int i = 0; i < OUT_WORDS; i++) begin
            w_flush_keep[i] = (i[IDX_W-1:0] < r_fill_idx);
        end
    end

    always_ff @(posedge kernel_clk or negedge kernel_resetn) begin
        if (!kernel_resetn) begin
            r_acc         <= '0;
            r_fill_idx    <= '0;
            r_timer       <= '0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_keep    <= '0;
            r_word_count  <= '0;
            r_flush_count <= '0;
        end else begin
            // Accumulator is cleared on hand-off so a later flush sees zero in unfilled lanes.
            if (w_load || w_flush) begin
                r_acc      <= '0;
                r_fill_idx <= '0;
            end else begin
                r_acc <= w_acc_nxt;
                if (w_accept) begin
                    r_fill_idx <= r_fill_idx + 1'b1;
                end
            end

            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_acc_nxt;
                r_out_keep  <= '1;
            end else if (w_flush) begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_acc;
                r_out_keep  <= w_flush_keep;
            end else if (w_oacc) begin
                r_out_valid <= 1'b0;
            end

            // Timer saturates at the expiry value so a stalled flush stays armed.
            if (w_accept || w_flush || r_fill_idx == '0) begin
                r_timer <= '0;
            end else if (r_timer != TMO_MAX) begin
                r_timer <= r_timer + 16'd1;
            end

            if (w_accept) begin
                r_word_count <= r_word_count + 1'b1;
            end
            if (w_flush && r_flush_count != 16'hFFFF) begin
                r_flush_count <= r_flush_count + 16'd1;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_keep    = r_out_keep;
    assign word_count  = r_word_count;
    assign flush_count = r_flush_count;

endmodule

// File: tb/tb_udp_rx_kernel_packer.sv
// Scoreboard bench for udp_rx_kernel_packer (OUT_WORDS=2, FLUSH_TIMEOUT=8).
module tb_udp_rx_kernel_packer;

    localparam int unsigned OW = 2;
    localparam int unsigned DW = 64 * OW;

    typedef struct {
        logic [DW-1:0] data;
        logic [OW-1:0] keep;
    } exp_t;

    logic          kernel_clk;
    logic          kernel_resetn;
    logic          in_valid;
    logic [63:0]   in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [OW-1:0] out_keep;
    logic          out_ready;
    logic          flush_en;
    logic [31:0]   word_count;
    logic [15:0]   flush_count;

    int   n_checks;
    int   n_fail;
    int   n_pushed;
    int   n_popped;
    exp_t exp_q[$];

    udp_rx_kernel_packer #(
        .OUT_WORDS    (OW),
        .FLUSH_TIMEOUT(8),
        .CNT_W        (32)
    ) dut (
        .kernel_clk   (kernel_clk),
        .kernel_resetn(kernel_resetn),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_keep     (out_keep),
        .out_ready    (out_ready),
        .flush_en     (flush_en),
        .word_count   (word_count),
        .flush_count  (flush_count)
    );

    initial kernel_clk = 1'b0;
    always #5 kernel_clk = ~kernel_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] sw(input logic [63:0] x);
        logic [63:0] r;
`ifdef UDP_RX_BYTESWAP_EN
        r = '0;
        for (int b = 0; b < 8; b++) r[8*b +: 8] = x[8*(7-b) +: 8];
`else
        r = x;
`endif
        return r;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [63:0] hi, input logic [63:0] lo, input logic [OW-1:0] keep);
        exp_t e;
        e.data = {hi, lo};
        e.keep = keep;
        exp_q.push_back(e);
        n_pushed++;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge kernel_clk);
            if (kernel_resetn && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", DW'(out_valid), '0);
                end else begin
                    e = exp_q.pop_front();
                    n_popped++;
                    check("out_data", out_data, e.data);
                    check("out_keep", DW'(out_keep), DW'(e.keep));
                end
            end
        end
    endtask

    // Presents one word and holds it until accepted (bounded).
    task automatic send(input logic [63:0] w);
        logic acc;
        int   n;
        in_valid = 1'b1;
        in_data  = w;
        n = 0;
        do begin
            @(negedge kernel_clk);
            acc = in_ready;
            @(posedge kernel_clk);
            #1;
            n++;
        end while (!acc && n < 100);
        if (!acc) check("send_timeout", '0, DW'(1));
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge kernel_clk);
        #1;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; n_pushed = 0; n_popped = 0;
        kernel_resetn = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1; flush_en = 1'b0;
        fork
            monitor();
        join_none

        #2;
        check("rst_in_ready",    DW'(in_ready),    DW'(1));
        check("rst_out_valid",   DW'(out_valid),   '0);
        check("rst_out_data",    out_data,         '0);
        check("rst_out_keep",    DW'(out_keep),    '0);
        check("rst_word_count",  DW'(word_count),  '0);
        check("rst_flush_count", DW'(flush_count), '0);
        idle(3);
        kernel_resetn = 1'b1;
        idle(2);

        // Two consecutive words pack into one output, one cycle after the second accept.
        push(sw(64'h2222), sw(64'h1111), 2'b11);
        send(64'h1111);
        send(64'h2222);
        check("t1_latency_valid", DW'(out_valid), DW'(1));
        check("t1_word_count", DW'(word_count), DW'(2));
        idle(4);

        // Single word flushed after the idle timeout.
        flush_en = 1'b1;
        push(64'h0, sw(64'hAAAA), 2'b01);
        send(64'hAAAA);
        for (int k = 1; k <= 7; k++) begin
            idle(1);
            check("t2_no_early_flush", DW'(out_valid), '0);
        end
        idle(1);
        check("t2_flush_valid", DW'(out_valid), DW'(1));
        check("t2_flush_count", DW'(flush_count), DW'(1));
        idle(4);
        check("t2_drained", DW'(out_valid), '0);

        // Flush disabled: partial word waits for the next input.
        flush_en = 1'b0;
        send(64'hAAAA);
        idle(1000);
        check("t3_no_flush", DW'(out_valid), '0);
        check("t3_flush_count", DW'(flush_count), DW'(1));
        push(sw(64'hBBBB), sw(64'hAAAA), 2'b11);
        send(64'hBBBB);
        idle(4);

        // Back-pressure: HOLD plus one filled lane, then drain back-to-back.
        out_ready = 1'b0;
        push(sw(64'hB1), sw(64'hB0), 2'b11);
        push(sw(64'hB3), sw(64'hB2), 2'b11);
        send(64'hB0);
        send(64'hB1);
        send(64'hB2);
        in_valid = 1'b1;
        in_data  = 64'hB3;
        idle(3);
        check("t4_stall_in_ready", DW'(in_ready), '0);
        check("t4_stall_valid", DW'(out_valid), DW'(1));
        check("t4_stall_data", out_data, {sw(64'hB1), sw(64'hB0)});
        out_ready = 1'b1;
        idle(1);
        in_valid = 1'b0;
        check("t4_b2b_valid", DW'(out_valid), DW'(1));
        idle(4);
        check("t4_word_count", DW'(word_count), DW'(9));
        check("t4_queue_empty", DW'(exp_q.size()), '0);

        // Reset mid-packet discards the partial lane.
        send(64'h5555);
        kernel_resetn = 1'b0;
        #2;
        check("t5_rst_valid", DW'(out_valid), '0);
        check("t5_rst_word_count", DW'(word_count), '0);
        check("t5_rst_flush_count", DW'(flush_count), '0);
        check("t5_rst_in_ready", DW'(in_ready), DW'(1));
        idle(2);
        kernel_resetn = 1'b1;
        idle(2);
        push(sw(64'h7777), sw(64'h6666), 2'b11);
        send(64'h6666);
        send(64'h7777);
        idle(3);
        check("t5_word_count", DW'(word_count), DW'(2));

        // Byte-order vector.
        push(sw(64'h0102030405060708), sw(64'h0102030405060708), 2'b11);
        send(64'h0102030405060708);
        send(64'h0102030405060708);
`ifdef UDP_RX_BYTESWAP_EN
        check("t6_lane0", DW'(out_data[63:0]), DW'(64'h0807060504030201));
`else
        check("t6_lane0", DW'(out_data[63:0]), DW'(64'h0102030405060708));
`endif
        idle(5);

        check("final_queue_empty", DW'(exp_q.size()), '0);
        check("final_pop_count", DW'(n_popped), DW'(n_pushed));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
